// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake and redirect request.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface instruction_fetch_unit_if;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    output imem_address,
    input  imem_instruction,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    input  redirect_valid,
    input  redirect_target
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    output redirect_valid,
    output redirect_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC register, IDLE/RUN/HALT control, and a 2-entry
// in-order buffer toward decode. Head entry lives in fixed registers so outputs are registered.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  output logic                      halted,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic [31:0] pc_r, pc_nx_s;
  logic [1:0]  count_r, count_nx_s;
  logic [31:0] head_pc_r, head_data_r, tail_pc_r, tail_data_r;
  logic [31:0] head_pc_nx_s, head_data_nx_s, tail_pc_nx_s, tail_data_nx_s;
  logic        valid_r, halted_r;
  logic        pop_s, fetch_s, push_s;

  // Handshake qualifiers; a fetched halt word is consumed but never pushed.
  always_comb begin
    pop_s   = (count_r != 2'd0) && bus.inst_ready;
    fetch_s = (state_r == RUN) && fetch_en && !bus.redirect_valid &&
              ((count_r < 2'd2) || pop_s);
    push_s  = fetch_s && (bus.imem_instruction != HALT_WORD);
  end

  // Control FSM next state; redirect outranks everything else.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.redirect_valid)  state_nx_s = IDLE;
        else if (fetch_en)       state_nx_s = RUN;
        else                     state_nx_s = IDLE;
      end
      RUN: begin
        if (bus.redirect_valid)      state_nx_s = RUN;
        else if (!fetch_en)          state_nx_s = IDLE;
        else if (fetch_s && !push_s) state_nx_s = HALT;
        else                         state_nx_s = RUN;
      end
      HALT: begin
        if (bus.redirect_valid) state_nx_s = RUN;
        else                    state_nx_s = HALT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Buffer and PC next values; unused slots are kept at zero so an empty head reads 0.
  always_comb begin
    count_nx_s     = count_r;
    head_pc_nx_s   = head_pc_r;
    head_data_nx_s = head_data_r;
    tail_pc_nx_s   = tail_pc_r;
    tail_data_nx_s = tail_data_r;
    pc_nx_s        = pc_r;
    if (bus.redirect_valid) begin
      count_nx_s     = 2'd0;
      head_pc_nx_s   = 32'h0000_0000;
      head_data_nx_s = 32'h0000_0000;
      tail_pc_nx_s   = 32'h0000_0000;
      tail_data_nx_s = 32'h0000_0000;
      pc_nx_s        = bus.redirect_target & 32'hFFFF_FFFC & ADDR_MASK;
    end else if (pop_s && push_s) begin
      if (count_r == 2'd2) begin
        head_pc_nx_s   = tail_pc_r;
        head_data_nx_s = tail_data_r;
        tail_pc_nx_s   = pc_r;
        tail_data_nx_s = bus.imem_instruction;
      end else begin
        head_pc_nx_s   = pc_r;
        head_data_nx_s = bus.imem_instruction;
      end
      pc_nx_s = (pc_r + 32'd4) & ADDR_MASK;
    end else if (pop_s) begin
      count_nx_s     = count_r - 2'd1;
      head_pc_nx_s   = tail_pc_r;
      head_data_nx_s = tail_data_r;
      tail_pc_nx_s   = 32'h0000_0000;
      tail_data_nx_s = 32'h0000_0000;
    end else if (push_s) begin
      count_nx_s = count_r + 2'd1;
      if (count_r == 2'd0) begin
        head_pc_nx_s   = pc_r;
        head_data_nx_s = bus.imem_instruction;
      end else begin
        tail_pc_nx_s   = pc_r;
        tail_data_nx_s = bus.imem_instruction;
      end
      pc_nx_s = (pc_r + 32'd4) & ADDR_MASK;
    end else begin
      count_nx_s = count_r;
    end
  end

  // State, PC, buffer and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      count_r     <= 2'd0;
      head_pc_r   <= 32'h0000_0000;
      head_data_r <= 32'h0000_0000;
      tail_pc_r   <= 32'h0000_0000;
      tail_data_r <= 32'h0000_0000;
      valid_r     <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      count_r     <= count_nx_s;
      head_pc_r   <= head_pc_nx_s;
      head_data_r <= head_data_nx_s;
      tail_pc_r   <= tail_pc_nx_s;
      tail_data_r <= tail_data_nx_s;
      valid_r     <= (count_nx_s != 2'd0);
      halted_r    <= (state_nx_s == HALT);
    end
  end

  assign bus.imem_address = pc_r;
  assign bus.inst_valid   = valid_r;
  assign bus.inst_data    = head_data_r;
  assign bus.inst_pc      = head_pc_r;
  assign halted           = halted_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: per-cycle vector table plus hand-written corner sequences,
// with a scoreboard queue of expected (pc, data) deliveries checked on every accepted pop.
module tb_instruction_fetch_unit;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fe_a = 1'b0;
  logic fe_b = 1'b0;
  logic halted_a, halted_b;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [4];
  ent_t exp_q [$];
  vec_t vecs [11];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if bus_a ();
  instruction_fetch_unit_if bus_b ();

  assign bus_a.imem_instruction = mem_a[bus_a.imem_address[9:2]];
  assign bus_b.imem_instruction = mem_b[bus_b.imem_address[3:2]];

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(256), .HALT_WORD(HALT)) dut_a (
    .clk(clk), .rst_n(rst_n), .fetch_en(fe_a), .halted(halted_a), .bus(bus_a)
  );

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4), .HALT_WORD(HALT)) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_en(fe_b), .halted(halted_b), .bus(bus_b)
  );

  function automatic logic [31:0] wa(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic fe, input logic rdy, input logic rv, input logic [31:0] tgt);
    fe_a = fe;
    bus_a.inst_ready = rdy;
    bus_a.redirect_valid = rv;
    bus_a.redirect_target = tgt;
  endtask

  task automatic drive_b(input logic fe, input logic rdy, input logic rv, input logic [31:0] tgt);
    fe_b = fe;
    bus_b.inst_ready = rdy;
    bus_b.redirect_valid = rv;
    bus_b.redirect_target = tgt;
  endtask

  task automatic expect_push(input logic [31:0] pc, input logic [31:0] data);
    ent_t e;
    e.pc = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Every accepted pop on DUT A (not squashed by a redirect) must match the queue head.
  always @(negedge clk) begin : sb_monitor
    ent_t e;
    if (rst_n && bus_a.inst_valid && bus_a.inst_ready && !bus_a.redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: actual pc=%h data=%h required no delivery",
                 bus_a.inst_pc, bus_a.inst_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus_a.inst_pc, e.pc);
        chk("sb_data", bus_a.inst_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wrap_seq [4];
    wrap_seq[0] = 32'h8; wrap_seq[1] = 32'hC; wrap_seq[2] = 32'h0; wrap_seq[3] = 32'h4;
    for (int i = 0; i < 256; i++) mem_a[i] = wa(i);
    for (int i = 0; i < 4; i++) mem_b[i] = 32'hB000_0000 + 32'(i);
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    drive_b(1'b0, 1'b0, 1'b0, 32'h0);

    // reset values
    repeat (2) tick();
    chk("rst_addr", bus_a.imem_address, 32'h0);
    chk("rst_valid", 32'(bus_a.inst_valid), 32'h0);
    chk("rst_data", bus_a.inst_data, 32'h0);
    chk("rst_pc", bus_a.inst_pc, 32'h0);
    chk("rst_halted", 32'(halted_a), 32'h0);
    rst_n = 1'b1;

    // idle cycles, startup latency and sequential streaming
    for (int k = 0; k < 5; k++) vecs[k] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h0, wa(0), 32'h4};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h4, wa(1), 32'h8};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h8, wa(2), 32'hC};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'hC, wa(3), 32'h10};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h10};
    for (int k = 0; k < 4; k++) expect_push(32'(k * 4), wa(k));
    for (int k = 0; k < 11; k++) begin
      drive_a(vecs[k].fe, vecs[k].rdy, 1'b0, 32'h0);
      tick();
      chk("vec_valid", 32'(bus_a.inst_valid), 32'(vecs[k].exp_valid));
      chk("vec_pc", bus_a.inst_pc, vecs[k].exp_pc);
      chk("vec_data", bus_a.inst_data, vecs[k].exp_data);
      chk("vec_addr", bus_a.imem_address, vecs[k].exp_addr);
    end
    chk("seq_drained", 32'(exp_q.size()), 32'h0);

    // backpressure: buffer fills, PC freezes at 0x8, then drains in order
    drive_a(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("idle_redir_addr", bus_a.imem_address, 32'h0);
    for (int k = 0; k < 3; k++) expect_push(32'(k * 4), wa(k));
    drive_a(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (5) tick();
    chk("bp_addr", bus_a.imem_address, 32'h8);
    chk("bp_valid", 32'(bus_a.inst_valid), 32'h1);
    chk("bp_head_pc", bus_a.inst_pc, 32'h0);
    drive_a(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    chk("bp_after_pc", bus_a.inst_pc, 32'hC);

    // redirect coincident with a pop while streaming
    drive_a(1'b1, 1'b1, 1'b1, 32'h23);
    tick();
    chk("rd_valid", 32'(bus_a.inst_valid), 32'h0);
    chk("rd_addr", bus_a.imem_address, 32'h20);
    expect_push(32'h20, wa(8));
    expect_push(32'h24, wa(9));
    drive_a(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("rd_first_pc", bus_a.inst_pc, 32'h20);
    tick();
    drive_a(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("rd_end_valid", 32'(bus_a.inst_valid), 32'h0);
    chk("rd_drained", 32'(exp_q.size()), 32'h0);

    // halt word at 0x10: buffered entries drain, halt word never delivered
    mem_a[4] = HALT;
    drive_a(1'b0, 1'b0, 1'b1, 32'h8);
    tick();
    expect_push(32'h8, wa(2));
    expect_push(32'hC, wa(3));
    drive_a(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) tick();
    chk("halt_stall_halted", 32'(halted_a), 32'h0);
    drive_a(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("halt_halted", 32'(halted_a), 32'h1);
    chk("halt_addr", bus_a.imem_address, 32'h10);
    chk("halt_head_pc", bus_a.inst_pc, 32'hC);
    repeat (2) tick();
    chk("halt_empty", 32'(bus_a.inst_valid), 32'h0);
    chk("halt_hold", 32'(halted_a), 32'h1);
    chk("halt_addr_hold", bus_a.imem_address, 32'h10);
    expect_push(32'h0, wa(0));
    drive_a(1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    chk("unhalt_halted", 32'(halted_a), 32'h0);
    chk("unhalt_addr", bus_a.imem_address, 32'h0);
    drive_a(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("unhalt_pc", bus_a.inst_pc, 32'h0);
    chk("unhalt_data", bus_a.inst_data, wa(0));
    drive_a(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("halt_drained", 32'(exp_q.size()), 32'h0);
    mem_a[4] = wa(4);

    // wrap on the 4-word instance
    drive_b(1'b0, 1'b1, 1'b1, 32'h8);
    tick();
    drive_b(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wrap_pc", bus_b.inst_pc, wrap_seq[k]);
      chk("wrap_data", bus_b.inst_data, 32'hB000_0000 + 32'(wrap_seq[k][3:2]));
    end

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", bus_b.imem_address, 32'h0);
    chk("arst_valid", 32'(bus_b.inst_valid), 32'h0);
    chk("arst_data", bus_b.inst_data, 32'h0);
    chk("arst_pc", bus_b.inst_pc, 32'h0);
    chk("arst_halted", 32'(halted_b), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bus_b.inst_valid), 32'h0);
    tick();
    chk("post_rst_valid", 32'(bus_b.inst_valid), 32'h1);
    chk("post_rst_pc", bus_b.inst_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch front end that drives the instruction memory. It owns the program counter, presents word-aligned addresses to the combinational instruction memory, and captures each returned instruction with its PC into a 2-entry buffer. The buffer feeds decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and also accepts branch/jump redirects and halts on a sentinel instruction.

## Interface
- RESET_PC, 32'h00000000, PC loaded on reset (must be word-aligned)
- MEM_WORDS, 256, instruction memory depth in 32-bit words; power of two
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- fetch_en  input  1  level; permits fetching
- imem_address  output  32  byte address to instruction memory; always equals PC
- imem_instruction  input  32  combinational read data for imem_address
- inst_valid  output  1  buffer head holds a valid instruction
- inst_ready  input  1  decode accepts head this cycle
- inst_data  output  32  head instruction
- inst_pc  output  32  head instruction's address
- redirect_valid  input  1  load new PC, flush buffer
- redirect_target  input  32  new PC byte address
- halted  output  1  high while in HALT state

## Operation
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- States: IDLE, RUN, HALT.
  - IDLE→RUN when fetch_en=1.
  - RUN→IDLE when fetch_en=0.
  - RUN→HALT when a captured instruction equals HALT_WORD.
  - HALT→RUN on redirect_valid.
  - Reset→IDLE.
- pop = inst_valid & inst_ready.
- fetch = (state==RUN) & fetch_en & ~redirect_valid & (count<2 | pop).
- On fetch with imem_instruction≠HALT_WORD:
  - push {PC, imem_instruction} to the buffer tail.
  - PC ← (PC+4) mod (MEM_WORDS*4).
- On fetch with imem_instruction==HALT_WORD: nothing is pushed, PC is held at the halt address, and the state goes to HALT.
- Entries already in the buffer keep draining in HALT and IDLE.
- Redirect has priority over everything:
  - count ← 0 and pending pop is discarded; no push.
  - PC ← {redirect_target[31:2],2'b00} mod (MEM_WORDS*4).
  - From HALT, go to RUN. From IDLE, stay IDLE. From RUN, stay RUN.
- Buffer: 2-entry FIFO, count 0..2, in-order delivery.
  - Simultaneous push and pop when full is legal; count stays 2.
  - Push when count==2 without pop never occurs (fetch is gated).
- Outputs:
  - inst_valid = (count≠0).
  - inst_data and inst_pc come from the head entry. They are 0 when count==0.
- Reset values: PC=RESET_PC, imem_address=RESET_PC, count=0, inst_valid=0, inst_data=0, inst_pc=0, halted=0, state=IDLE.

## Timing
- imem_address is a register output. The instruction is sampled from imem_instruction on the same edge the PC advances. There is no wait state.
- Startup latency: fetch_en sampled high in IDLE at edge N → RUN after N. First capture at edge N+1. inst_valid high after N+1.
- Throughput: 1 instruction/cycle when inst_ready is held high.
- Stall behaviour with inst_ready=0: two captures fill the buffer, then the PC freezes. Fetch resumes on the same edge as the first pop.
- Redirect: asserted at edge M → inst_valid=0 after M, PC=target after M, first new entry captured at M+1.
- halted follows the state register: it rises on the edge that captures HALT_WORD.
- Wrap: the last word address (MEM_WORDS*4-4) is followed by address 0.
- rst_n low mid-operation clears all state immediately (asynchronous). The first fetch after deassertion requires fetch_en to be sampled high again.

## Test plan
- Reset: hold rst_n=0 → imem_address=0, inst_valid=0, inst_data=0, inst_pc=0, halted=0. Release with fetch_en=0 → no change for 5 cycles.
- Sequential fetch: memory holds words W0..W3 at 0x0/0x4/0x8/0xC; fetch_en=1, inst_ready=1 → inst_valid from the 2nd edge after enable, delivering (0x0,W0),(0x4,W1),(0x8,W2),(0xC,W3) on consecutive cycles.
- Backpressure: inst_ready=0 → exactly 2 entries held, imem_address stuck at 0x8. Raise inst_ready → W0,W1,W2 delivered in order, no duplicates or gaps.
- Redirect: while streaming, redirect_valid=1 with target 0x23 → buffer flushed, next delivered inst_pc=0x20. Redirect coincident with pop → popped entry not redelivered, no stale entries.
- Halt: word at 0x10 = 32'hFFFFFFFF → halted=1, imem_address=0x10, 0x10 never delivered, buffered W2,W3 still drain. Redirect to 0x0 → halted=0, fetch restarts at 0x0.
- Wrap and reset: MEM_WORDS=4, stream from 0x8 → inst_pc sequence 0x8,0xC,0x0,0x4. Assert rst_n=0 mid-stream → outputs return to reset values within the same cycle.
